// File: rtl/mmult_opt_mdc_out_r_tracker.sv
// out_r skid buffer + job beat tracker for mmult_opt_mdc.
// Define MMULT_OPT_MDC_OUT_R_PERF_EN to enable the sink stall counter.
module mmult_opt_mdc_out_r_tracker #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  cnt_limit_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [1:0]            r_occ;
  logic [1:0]            w_occ_nxt;
  logic [CNT_WIDTH-1:0]  r_limit;
  logic [CNT_WIDTH-1:0]  w_limit_nxt;
  logic [CNT_WIDTH-1:0]  r_in_cnt;
  logic [CNT_WIDTH-1:0]  w_in_cnt_nxt;
  logic [CNT_WIDTH-1:0]  r_out_cnt;
  logic [CNT_WIDTH-1:0]  w_out_cnt_nxt;
  logic                  r_in_ready;
  logic                  w_in_ready_nxt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_start;
  logic                  w_busy;

  assign w_push  = in_valid_i & r_in_ready;
  assign w_pop   = (r_occ != 2'd0) & out_ready_i;
  assign w_start = start_i & (r_state == S_IDLE);
  assign w_busy  = (r_state == S_RUN) | (r_state == S_DRAIN);

  always_comb begin
    w_state_nxt   = r_state;
    w_limit_nxt   = r_limit;
    w_in_cnt_nxt  = r_in_cnt + CNT_WIDTH'(w_push);
    w_out_cnt_nxt = r_out_cnt + CNT_WIDTH'(w_pop);
    w_occ_nxt     = r_occ + {1'b0, w_push} - {1'b0, w_pop};
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_limit_nxt   = cnt_limit_i;
          w_in_cnt_nxt  = '0;
          w_out_cnt_nxt = '0;
          w_state_nxt   = (cnt_limit_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_push && (w_in_cnt_nxt == r_limit))
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((r_out_cnt == r_limit) && (r_occ == 2'd0))
          w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // ready is registered, so it looks one cycle ahead
    w_in_ready_nxt = (w_state_nxt == S_RUN) &&
                     (w_occ_nxt < 2'd2) &&
                     (w_in_cnt_nxt < w_limit_nxt);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_head     <= '0;
      r_tail     <= '0;
      r_occ      <= 2'd0;
      r_limit    <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_in_ready <= 1'b0;
    end else if (clear_i) begin
      r_state    <= S_IDLE;
      r_head     <= '0;
      r_tail     <= '0;
      r_occ      <= 2'd0;
      r_limit    <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_occ      <= w_occ_nxt;
      r_limit    <= w_limit_nxt;
      r_in_cnt   <= w_in_cnt_nxt;
      r_out_cnt  <= w_out_cnt_nxt;
      r_in_ready <= w_in_ready_nxt;
      unique case (1'b1)
        (r_occ == 2'd2): begin
          if (w_pop) r_head <= r_tail;
        end
        (r_occ == 2'd1): begin
          if (w_push && w_pop) r_head <= in_data_i;
          else if (w_push)     r_tail <= in_data_i;
        end
        default: begin
          if (w_push) r_head <= in_data_i;
        end
      endcase
    end
  end

`ifdef MMULT_OPT_MDC_OUT_R_PERF_EN
  logic [CNT_WIDTH-1:0] r_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall <= '0;
    end else if (clear_i || w_start) begin
      r_stall <= '0;
    end else if (w_busy && out_valid_o && !out_ready_i &&
                 (r_stall != '1)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall;
`else
  assign stall_cnt_o = '0;
`endif

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = (r_occ != 2'd0);
  assign out_data_o  = r_head;
  assign busy_o      = w_busy;
  assign done_o      = (r_state == S_DONE);
  assign cnt_o       = r_out_cnt;

endmodule

// File: tb/tb_mmult_opt_mdc_out_r_tracker.sv
// Randomized bench for mmult_opt_mdc_out_r_tracker.
// Reference model: beat counts plus a data queue.
module tb_mmult_opt_mdc_out_r_tracker;

  localparam int DW = 32;
  localparam int CW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clear_i;
  logic          start_i;
  logic [CW-1:0] cnt_limit_i;
  logic [DW-1:0] in_data_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] out_data_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] cnt_o;
  logic [CW-1:0] stall_cnt_o;

  mmult_opt_mdc_out_r_tracker #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .start_i    (start_i),
    .cnt_limit_i(cnt_limit_i),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .out_data_o (out_data_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .cnt_o      (cnt_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  bit            m_job;
  bit            m_done;
  int unsigned   m_lim;
  int unsigned   m_acc;
  int unsigned   m_dlv;
  int unsigned   m_stall;
  logic [DW-1:0] m_q[$];
  bit            e_ready;
  bit            e_valid;
  bit            e_busy;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_job   = 1'b0;
    m_done  = 1'b0;
    m_lim   = 0;
    m_acc   = 0;
    m_dlv   = 0;
    m_stall = 0;
    m_q.delete();
  endfunction

  function automatic void m_expect();
    e_busy  = m_job && !m_done;
    e_valid = (m_acc != m_dlv);
    e_ready = e_busy && (m_acc < m_lim) && ((m_acc - m_dlv) < 2);
  endfunction

  function automatic void m_edge();
    bit hi;
    bit ho;
    bit fin;
    if (clear_i) begin
      m_reset();
    end else if (m_done) begin
      m_done = 1'b0;
      m_job  = 1'b0;
    end else if (m_job) begin
      hi  = e_ready && in_valid_i;
      ho  = e_valid && out_ready_i;
      fin = (m_acc == m_lim) && (m_dlv == m_lim);
      if (e_busy && e_valid && !out_ready_i) m_stall++;
      if (ho) void'(m_q.pop_front());
      if (hi) m_q.push_back(in_data_i);
      m_acc += hi;
      m_dlv += ho;
      if (fin) m_done = 1'b1;
    end else if (start_i) begin
      m_job   = 1'b1;
      m_lim   = cnt_limit_i;
      m_acc   = 0;
      m_dlv   = 0;
      m_stall = 0;
      m_q.delete();
      if (m_lim == 0) m_done = 1'b1;
    end
  endfunction

  task automatic chk_outs(input string t);
    chk({t, ".in_ready"},  in_ready_o,  e_ready);
    chk({t, ".out_valid"}, out_valid_o, e_valid);
    chk({t, ".busy"},      busy_o,      e_busy);
    chk({t, ".done"},      done_o,      m_done);
    chk({t, ".cnt"},       cnt_o,       m_dlv);
`ifdef MMULT_OPT_MDC_OUT_R_PERF_EN
    chk({t, ".stall"},     stall_cnt_o, m_stall);
`else
    chk({t, ".stall"},     stall_cnt_o, 0);
`endif
    if (e_valid) chk({t, ".data"}, out_data_o, m_q[0]);
  endtask

  task automatic tick(input string t);
    @(posedge clk_i);
    m_edge();
    #1;
    m_expect();
    chk_outs(t);
  endtask

  // rpct < 0 means sink ready only every 3rd cycle
  task automatic run_job(input string t, input int lim, input int vpct,
                         input int rpct, input bit seqd, input bit noise);
    int n;
    n           = 0;
    start_i     = 1'b1;
    cnt_limit_i = CW'(lim);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    tick(t);
    start_i = 1'b0;
    while (m_job && n < 400) begin
      in_valid_i  = ($urandom_range(99) < vpct);
      in_data_i   = seqd ? DW'(32'hA0 + m_acc) : $urandom;
      out_ready_i = (rpct < 0) ? (n % 3 == 2) : ($urandom_range(99) < rpct);
      start_i     = noise && ($urandom_range(7) == 0);
      cnt_limit_i = $urandom;
      tick(t);
      n++;
    end
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    chk({t, ".timeout"}, m_job, 0);
    chk({t, ".final_cnt"}, cnt_o, lim);
  endtask

  initial begin
    int n;
    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    start_i     = 1'b0;
    cnt_limit_i = '0;
    in_data_i   = '0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    m_reset();
    m_expect();
    #12;
    chk_outs("reset");
    chk("reset.data", out_data_o, 0);
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    tick("idle");

    run_job("basic", 4, 100, 100, 1'b1, 1'b0);
    repeat (2) tick("basic_hold");
    run_job("bp", 3, 100, -1, 1'b0, 1'b0);
    run_job("excess", 2, 100, 100, 1'b0, 1'b0);
    run_job("zero", 0, 100, 100, 1'b0, 1'b0);
    tick("zero_idle");

    // clear with two beats buffered
    start_i     = 1'b1;
    cnt_limit_i = 8;
    tick("clr");
    start_i = 1'b0;
    n       = 0;
    while (!(m_acc == 3 && (m_acc - m_dlv) == 2) && n < 30) begin
      in_valid_i  = 1'b1;
      in_data_i   = $urandom;
      out_ready_i = (m_dlv == 0);
      tick("clr");
      n++;
    end
    chk("clr.setup", m_acc, 3);
    clear_i    = 1'b1;
    in_valid_i = 1'b0;
    tick("clr_edge");
    clear_i = 1'b0;
    repeat (3) tick("clr_after");

    // async reset while draining
    start_i     = 1'b1;
    cnt_limit_i = 2;
    tick("arst");
    start_i = 1'b0;
    n       = 0;
    while (m_acc < 2 && n < 20) begin
      in_valid_i  = 1'b1;
      in_data_i   = $urandom;
      out_ready_i = 1'b0;
      tick("arst");
      n++;
    end
    chk("arst.in_drain", busy_o && !in_ready_o && m_acc == 2, 1);
    in_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    m_reset();
    m_expect();
    chk_outs("arst_now");
    chk("arst.data", out_data_o, 0);
    #10 rst_ni = 1'b1;
    run_job("post_rst", 1, 100, 100, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      run_job("rand", $urandom_range(0, 7), $urandom_range(20, 100),
              $urandom_range(10, 100), 1'b0, 1'b1);
      if ($urandom_range(1) == 1) tick("rand_gap");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
